// File: rtl/vctrl_pkg.sv
// Shared definitions for the vector-aware control sequencer: opcodes, ALUOp classes,
// the registered control bundle and the sequencer FSM states.
package vctrl_pkg;

  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPV    = 7'b1010111;
  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    vreg_write;
    logic    mem_rd;
    logic    mem_wr;
    logic    vmem_wr;
    logic    branch;
    logic    mem_to_reg;
    logic    alu_src;
    logic    imm_select;
    logic    reg_dst;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    SCALAR,
    VEC
  } state_e;

endpackage

// File: rtl/vctrl_decode.sv
// Combinational opcode-to-control-bundle decode.
// Vector memory opcodes are decoded only when VCTRL_VMEM_EN is defined.
module vctrl_decode
  import vctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       vec_o
);

  always_comb begin
    ctrl_o = CTRL_NONE;
    vec_o  = 1'b0;
    case (opcode_i)
      OPC_ADDI: begin
        ctrl_o.alu_op    = ALU_IMM;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      OPC_RTYPE: begin
        ctrl_o.alu_op    = ALU_RTYPE;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.alu_op  = ALU_SUB;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.branch  = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_rd     = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_wr     = 1'b1;
        ctrl_o.imm_select = 1'b1;
      end
      OPC_OPV: begin
        ctrl_o.vreg_write = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        vec_o             = 1'b1;
      end
`ifdef VCTRL_VMEM_EN
      OPC_VLOAD: begin
        ctrl_o.mem_rd     = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.vreg_write = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        vec_o             = 1'b1;
      end
      OPC_VSTORE: begin
        ctrl_o.vmem_wr    = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.imm_select = 1'b1;
        vec_o             = 1'b1;
      end
`endif
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vctrl_seq.sv
// Control sequencer: registers decoded bundles and splits vector ops into LANES-wide beats.
// Define VCTRL_VMEM_EN to sequence vector load/store opcodes.
module vctrl_seq
  import vctrl_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned ELEN  = 32,
  parameter int unsigned VLEN  = 256,
  localparam int unsigned VLMAX = VLEN / ELEN,
  localparam int unsigned VLW   = $clog2(VLMAX) + 1,
  localparam int unsigned BW    = $clog2(VLMAX / LANES) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             instr_valid_i,
  input  logic [31:0]      instr_i,
  input  logic [VLW-1:0]   vl_i,
  output logic             instr_ready_o,
  output logic             ctrl_valid_o,
  input  logic             ctrl_ready_i,
  output logic             RegWrite_o,
  output logic             VRegWrite_o,
  output logic             MemRd_o,
  output logic             MemWr_o,
  output logic             VMemWr_o,
  output logic             Branch_o,
  output logic             MemToReg_o,
  output logic             ALUSrc_o,
  output logic             immSelect_o,
  output logic             RegDst_o,
  output logic [1:0]       ALUOp_o,
  output logic [BW-1:0]    beat_idx_o,
  output logic             last_o,
  output logic [LANES-1:0] lane_mask_o,
  output logic             busy_o,
  output logic             illegal_o
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
  logic             dec_vec;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [BW-1:0]    last_idx_q, last_idx_d;
  logic [VLW-1:0]   vl_q, vl_d, vl_eff;
  logic [LANES-1:0] mask_q, mask_d;
  logic             accept, hs;
  logic             unused_instr;

  assign unused_instr = ^instr_i[31:7];

  vctrl_decode u_decode (
    .opcode_i (instr_i[6:0]),
    .ctrl_o   (dec_ctrl),
    .vec_o    (dec_vec)
  );

  function automatic logic [BW-1:0] last_beat(input logic [VLW-1:0] vl);
    int unsigned nb;
    nb = (32'(vl) + LANES - 1) / LANES;
    return BW'(nb - 1);
  endfunction

  // Tail beat keeps only the lanes still covered by vl; a full tail keeps all lanes.
  function automatic logic [LANES-1:0] tail_mask(input logic [VLW-1:0] vl);
    logic [LANES-1:0] m;
    int unsigned rem;
    rem = 32'(vl) % LANES;
    if (rem == 0) rem = LANES;
    for (int unsigned i = 0; i < LANES; i++) m[i] = (i < rem);
    return m;
  endfunction

  assign vl_eff        = (vl_i > VLW'(VLMAX)) ? VLW'(VLMAX) : vl_i;
  assign instr_ready_o = (state_q != VEC) && (!valid_q || ctrl_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;
  assign hs            = valid_q && ctrl_ready_i;

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    last_d     = last_q;
    beat_d     = beat_q;
    last_idx_d = last_idx_q;
    vl_d       = vl_q;
    mask_d     = mask_q;
    case (state_q)
      IDLE, SCALAR: begin
        // Consuming the current bundle first lets a same-cycle accept overwrite it.
        if (hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ctrl_d  = CTRL_NONE;
          last_d  = 1'b0;
          beat_d  = '0;
          mask_d  = '1;
        end
        if (accept) begin
          if (!dec_vec) begin
            state_d = SCALAR;
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            last_d  = 1'b0;
            beat_d  = '0;
            mask_d  = '1;
          end else if (vl_eff != '0) begin
            state_d    = VEC;
            ctrl_d     = dec_ctrl;
            valid_d    = 1'b1;
            beat_d     = '0;
            vl_d       = vl_eff;
            last_idx_d = last_beat(vl_eff);
            last_d     = (last_idx_d == '0);
            mask_d     = last_d ? tail_mask(vl_eff) : '1;
          end
        end
      end
      VEC: begin
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ctrl_d  = CTRL_NONE;
            last_d  = 1'b0;
            beat_d  = '0;
            mask_d  = '1;
          end else begin
            beat_d = beat_q + 1'b1;
            last_d = (beat_d == last_idx_q);
            mask_d = last_d ? tail_mask(vl_q) : '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ctrl_q     <= CTRL_NONE;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      beat_q     <= '0;
      last_idx_q <= '0;
      vl_q       <= '0;
      mask_q     <= '1;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      last_idx_q <= last_idx_d;
      vl_q       <= vl_d;
      mask_q     <= mask_d;
    end
  end

  assign ctrl_valid_o = valid_q;
  assign RegWrite_o   = ctrl_q.reg_write;
  assign VRegWrite_o  = ctrl_q.vreg_write;
  assign MemRd_o      = ctrl_q.mem_rd;
  assign MemWr_o      = ctrl_q.mem_wr;
  assign VMemWr_o     = ctrl_q.vmem_wr;
  assign Branch_o     = ctrl_q.branch;
  assign MemToReg_o   = ctrl_q.mem_to_reg;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign immSelect_o  = ctrl_q.imm_select;
  assign RegDst_o     = ctrl_q.reg_dst;
  assign ALUOp_o      = ctrl_q.alu_op;
  assign illegal_o    = ctrl_q.illegal;
  assign beat_idx_o   = beat_q;
  assign last_o       = last_q;
  assign lane_mask_o  = mask_q;
  assign busy_o       = (state_q == VEC);

endmodule

// File: tb/tb_vctrl_seq.sv
// Self-checking bench for vctrl_seq: vector table plus scoreboard of expected bundles,
// with hand-written stall, vl=0 and mid-sequence reset sequences.
module tb_vctrl_seq;

  localparam int unsigned LANES = 4;
  localparam int unsigned ELEN  = 32;
  localparam int unsigned VLEN  = 256;
  localparam int unsigned VLMAX = 8;
  localparam int unsigned VLW   = 4;
  localparam int unsigned BW    = 2;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             instr_valid_i;
  logic [31:0]      instr_i;
  logic [VLW-1:0]   vl_i;
  logic             instr_ready_o;
  logic             ctrl_valid_o;
  logic             ctrl_ready_i;
  logic             RegWrite_o, VRegWrite_o, MemRd_o, MemWr_o, VMemWr_o;
  logic             Branch_o, MemToReg_o, ALUSrc_o, immSelect_o, RegDst_o;
  logic [1:0]       ALUOp_o;
  logic [BW-1:0]    beat_idx_o;
  logic             last_o;
  logic [LANES-1:0] lane_mask_o;
  logic             busy_o;
  logic             illegal_o;

  vctrl_seq #(.LANES(LANES), .ELEN(ELEN), .VLEN(VLEN)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .vl_i          (vl_i),
    .instr_ready_o (instr_ready_o),
    .ctrl_valid_o  (ctrl_valid_o),
    .ctrl_ready_i  (ctrl_ready_i),
    .RegWrite_o    (RegWrite_o),
    .VRegWrite_o   (VRegWrite_o),
    .MemRd_o       (MemRd_o),
    .MemWr_o       (MemWr_o),
    .VMemWr_o      (VMemWr_o),
    .Branch_o      (Branch_o),
    .MemToReg_o    (MemToReg_o),
    .ALUSrc_o      (ALUSrc_o),
    .immSelect_o   (immSelect_o),
    .RegDst_o      (RegDst_o),
    .ALUOp_o       (ALUOp_o),
    .beat_idx_o    (beat_idx_o),
    .last_o        (last_o),
    .lane_mask_o   (lane_mask_o),
    .busy_o        (busy_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // en order: RegWrite VRegWrite MemRd MemWr VMemWr Branch MemToReg ALUSrc immSelect RegDst
  typedef struct packed {
    logic [9:0]       en;
    logic [1:0]       aluop;
    logic             illegal;
    logic [BW-1:0]    beat;
    logic             last;
    logic [LANES-1:0] mask;
    logic             busy;
  } bundle_t;

  typedef struct {
    logic [6:0]  op;
    int unsigned vl;
    logic [9:0]  en;
    logic [1:0]  aluop;
    logic        illegal;
    logic        vec;
  } vec_t;

  vec_t    tab[13];
  bundle_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input int unsigned vl, input logic [9:0] en,
                              input logic [1:0] aluop, input logic ill, input logic vec);
    vec_t r;
    r.op = op; r.vl = vl; r.en = en; r.aluop = aluop; r.illegal = ill; r.vec = vec;
    return r;
  endfunction

  function automatic bundle_t observed();
    bundle_t b;
    b.en      = {RegWrite_o, VRegWrite_o, MemRd_o, MemWr_o, VMemWr_o,
                 Branch_o, MemToReg_o, ALUSrc_o, immSelect_o, RegDst_o};
    b.aluop   = ALUOp_o;
    b.illegal = illegal_o;
    b.beat    = beat_idx_o;
    b.last    = last_o;
    b.mask    = lane_mask_o;
    b.busy    = busy_o;
    return b;
  endfunction

  function automatic logic [31:0] all_outputs();
    return 32'({ctrl_valid_o, busy_o, illegal_o, last_o,
                RegWrite_o, VRegWrite_o, MemRd_o, MemWr_o, VMemWr_o,
                Branch_o, MemToReg_o, ALUSrc_o, immSelect_o, RegDst_o,
                ALUOp_o, beat_idx_o, lane_mask_o});
  endfunction

  // Expected bundles for one accepted instruction, one entry per beat.
  task automatic push_row(input vec_t r);
    bundle_t     b;
    int unsigned vl, nb, rem;
    b = '0;
    b.en = r.en; b.aluop = r.aluop; b.illegal = r.illegal;
    if (!r.vec) begin
      b.mask = '1;
      exp_q.push_back(b);
    end else begin
      vl = (r.vl > VLMAX) ? VLMAX : r.vl;
      if (vl == 0) return;
      nb  = (vl + LANES - 1) / LANES;
      rem = vl - (nb - 1) * LANES;
      for (int unsigned k = 0; k < nb; k++) begin
        b.beat = BW'(k);
        b.last = (k == nb - 1);
        b.busy = 1'b1;
        for (int unsigned i = 0; i < LANES; i++) b.mask[i] = b.last ? (i < rem) : 1'b1;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic issue(input vec_t r, input logic chk_rdy);
    int unsigned n;
    n = 0;
    instr_valid_i = 1'b1;
    instr_i       = {25'($urandom), r.op};
    vl_i          = VLW'(r.vl);
    if (chk_rdy) check("instr_ready_no_stall", 32'(instr_ready_o), 32'd1);
    while (!instr_ready_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!instr_ready_o) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: actual ready 0 required 1 within 100 cycles");
    end else begin
      push_row(r);
    end
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i && ctrl_valid_o && ctrl_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_bundle: actual %0h required none", 32'(observed()));
      end else begin
        check("bundle", 32'(observed()), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] RESET_OUTS = 32'h0000_000F;

  initial begin
    vec_t r;
    logic prev_vec;

    rst_n_i = 1'b0; ctrl_ready_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; vl_i = '0;

    tab[0]  = mk(7'b0010011, 0, 10'b1000000101, 2'b11, 1'b0, 1'b0);
    tab[1]  = mk(7'b0110011, 0, 10'b1000000001, 2'b10, 1'b0, 1'b0);
    tab[2]  = mk(7'b1100011, 0, 10'b0000010100, 2'b01, 1'b0, 1'b0);
    tab[3]  = mk(7'b0000011, 0, 10'b1010001100, 2'b00, 1'b0, 1'b0);
    tab[4]  = mk(7'b0100011, 0, 10'b0001000110, 2'b00, 1'b0, 1'b0);
    tab[5]  = mk(7'b1111111, 0, 10'b0000000000, 2'b00, 1'b1, 1'b0);
`ifdef VCTRL_VMEM_EN
    tab[6]  = mk(7'b0000111, 5, 10'b0110001100, 2'b00, 1'b0, 1'b1);
    tab[7]  = mk(7'b0100111, 4, 10'b0000100110, 2'b00, 1'b0, 1'b1);
`else
    tab[6]  = mk(7'b0000111, 5, 10'b0000000000, 2'b00, 1'b1, 1'b0);
    tab[7]  = mk(7'b0100111, 4, 10'b0000000000, 2'b00, 1'b1, 1'b0);
`endif
    tab[8]  = mk(7'b1010111, 8, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    tab[9]  = mk(7'b1010111, 3, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    tab[10] = mk(7'b1010111, 15, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    tab[11] = mk(7'b1010111, 1, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    tab[12] = mk(7'b0010011, 0, 10'b1000000101, 2'b11, 1'b0, 1'b0);

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_outputs", all_outputs(), RESET_OUTS);
    rst_n_i = 1'b1;
    check("ready_after_release", 32'(instr_ready_o), 32'd1);

    prev_vec = 1'b0;
    for (int unsigned i = 0; i < 13; i++) begin
      issue(tab[i], !prev_vec);
      prev_vec = tab[i].vec;
    end
    drain();

    // Stall beat 0 of a vl=6 op; beat 1 carries the two-lane tail.
    ctrl_ready_i = 1'b0;
    r = mk(7'b1010111, 6, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    issue(r, 1'b1);
    for (int unsigned k = 0; k < 3; k++) begin
      check("stall_valid", 32'(ctrl_valid_o), 32'd1);
      check("stall_hold", 32'(observed()), 32'(exp_q[0]));
      check("stall_ready_low", 32'(instr_ready_o), 32'd0);
      @(posedge clk_i); #1;
    end
    ctrl_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("tail_ready_low", 32'(instr_ready_o), 32'd0);
    check("tail_mask", 32'(lane_mask_o), 32'h3);
    drain();

    // vl=0 vector op is accepted but produces nothing.
    r = mk(7'b1010111, 0, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    issue(r, 1'b1);
    for (int unsigned k = 0; k < 3; k++) begin
      check("vl0_no_bundle", 32'({ctrl_valid_o, busy_o, instr_ready_o}), 32'b001);
      @(posedge clk_i); #1;
    end

    // Reset while beat 1 of a vl=8 op is pending.
    r = mk(7'b1010111, 8, 10'b0100000001, 2'b00, 1'b0, 1'b1);
    issue(r, 1'b1);
    @(posedge clk_i); #1;
    ctrl_ready_i = 1'b0;
    check("pre_reset_beat", 32'(beat_idx_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("midseq_reset_outputs", all_outputs(), RESET_OUTS);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    ctrl_ready_i = 1'b1;
    check("post_reset_idle", 32'({instr_ready_o, busy_o, ctrl_valid_o}), 32'b100);
    issue(tab[0], 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
